// File: rtl/enemy_manager_if.sv
// enemy_manager_if: bullet-hit request handshake into the enemy manager.
// The hit source drives valid/slot; the manager answers with ready.
interface enemy_manager_if;
  logic       hit_valid;
  logic [2:0] hit_slot;
  logic       hit_ready;

  modport master (
    output hit_valid,
    output hit_slot,
    input  hit_ready
  );

  modport slave (
    input  hit_valid,
    input  hit_slot,
    output hit_ready
  );
endinterface

// File: rtl/enemy_manager.sv
// enemy_manager: per-frame enemy slot sequencer (move, spawn, hits).
// Optional macro ENEMY_SPEEDUP_EN: kill counter speeds up descent.
module enemy_manager #(
  parameter int N_SLOTS      = 5,
  parameter int SPAWN_PERIOD = 60,
  parameter int STEP         = 1,
  parameter int Y_START      = 8,
  parameter int Y_LIMIT      = 472,
  parameter int X_MIN        = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   frame_tick,
  enemy_manager_if.slave         hit,
  output logic [N_SLOTS-1:0]     enemy_active,
  output logic [10*N_SLOTS-1:0]  enemy_x,
  output logic [10*N_SLOTS-1:0]  enemy_y,
  output logic [2*N_SLOTS-1:0]   enemy_type,
  output logic [4*N_SLOTS-1:0]   enemy_health,
  output logic                   kill_pulse,
  output logic [1:0]             kill_type,
  output logic                   escape_pulse
);
  typedef enum logic [1:0] {IDLE, MOVE, SPAWN} state_t;

  localparam logic [2:0]  LAST    = 3'(N_SLOTS - 1);
  localparam logic [15:0] CNT_TOP = 16'(SPAWN_PERIOD - 1);

  state_t             state;
  logic [2:0]         idx;
  logic               pending;
  logic               ready;
  logic [15:0]        spawn_cnt;
  logic [15:0]        lfsr;
  logic [N_SLOTS-1:0] act;
  logic [9:0]         xs  [N_SLOTS];
  logic [9:0]         ys  [N_SLOTS];
  logic [1:0]         tys [N_SLOTS];
  logic [3:0]         hps [N_SLOTS];

  logic [9:0] step;
  logic [9:0] cur_y;
  logic [9:0] y_new;
  logic       hit_live;
  logic [3:0] hit_hp;
  logic [1:0] hit_ty;
  logic       free_ok;
  logic [2:0] free_idx;
  logic [1:0] new_ty;
  logic [3:0] new_hp;
  logic [9:0] new_x;
  logic       accept;

  assign hit.hit_ready = ready;
  assign accept = hit.hit_valid && ready;

`ifdef ENEMY_SPEEDUP_EN
  logic [5:0] kill_cnt;

  // Saturating kill count; every 16 kills adds one pixel of step
  always_ff @(posedge clk) begin
    if (reset) begin
      kill_cnt <= '0;
    end else if (accept && hit_live && hit_hp <= 4'd1
                 && kill_cnt != 6'h3f) begin
      kill_cnt <= kill_cnt + 6'd1;
    end
  end

  assign step = 10'(STEP) + 10'(kill_cnt >> 4);
`else
  assign step = 10'(STEP);
`endif

  // Slot lookups: hit target, slot under MOVE, lowest free slot
  always_comb begin
    hit_live = 1'b0;
    hit_hp   = '0;
    hit_ty   = '0;
    cur_y    = '0;
    free_ok  = 1'b0;
    free_idx = '0;
    for (int i = 0; i < N_SLOTS; i++) begin
      if (hit.hit_slot == 3'(i)) begin
        hit_live = act[i];
        hit_hp   = hps[i];
        hit_ty   = tys[i];
      end
      if (idx == 3'(i)) cur_y = ys[i];
    end
    for (int i = N_SLOTS - 1; i >= 0; i--) begin
      if (!act[i]) begin
        free_ok  = 1'b1;
        free_idx = 3'(i);
      end
    end
  end

  assign y_new = cur_y + step;

  // New enemy attributes drawn from the free-running LFSR
  always_comb begin
    new_ty = (lfsr[10:9] == 2'd3) ? 2'd2 : lfsr[10:9];
    new_x  = 10'(X_MIN) + {1'b0, lfsr[8:0]};
    unique case (1'b1)
      (new_ty == 2'd0): new_hp = 4'd1;
      (new_ty == 2'd1): new_hp = 4'd3;
      default:          new_hp = 4'd4;
    endcase
  end

  // Fibonacci LFSR, taps 16,14,13,11, stepping every cycle
  always_ff @(posedge clk) begin
    if (reset) lfsr <= 16'hACE1;
    else lfsr <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
  end

  // Frame sequencer: IDLE takes hits, MOVE walks slots, SPAWN fills one
  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      idx          <= '0;
      pending      <= 1'b0;
      ready        <= 1'b0;
      spawn_cnt    <= '0;
      kill_pulse   <= 1'b0;
      kill_type    <= '0;
      escape_pulse <= 1'b0;
      act          <= '0;
      for (int i = 0; i < N_SLOTS; i++) begin
        xs[i]  <= '0;
        ys[i]  <= '0;
        tys[i] <= '0;
        hps[i] <= '0;
      end
    end else begin
      kill_pulse   <= 1'b0;
      escape_pulse <= 1'b0;
      unique case (state)
        IDLE: begin
          if (accept && hit_live) begin
            for (int i = 0; i < N_SLOTS; i++) begin
              if (hit.hit_slot == 3'(i)) begin
                if (hit_hp > 4'd1) begin
                  hps[i] <= hit_hp - 4'd1;
                end else begin
                  act[i]     <= 1'b0;
                  xs[i]      <= '0;
                  ys[i]      <= '0;
                  tys[i]     <= '0;
                  hps[i]     <= '0;
                  kill_pulse <= 1'b1;
                  kill_type  <= hit_ty;
                end
              end
            end
          end
          if (frame_tick || pending) begin
            state   <= MOVE;
            idx     <= '0;
            pending <= 1'b0;
            ready   <= 1'b0;
          end else begin
            ready <= 1'b1;
          end
        end
        MOVE: begin
          if (frame_tick) pending <= 1'b1;
          for (int i = 0; i < N_SLOTS; i++) begin
            if (idx == 3'(i) && act[i]) begin
              if (y_new >= 10'(Y_LIMIT)) begin
                act[i]       <= 1'b0;
                xs[i]        <= '0;
                ys[i]        <= '0;
                tys[i]       <= '0;
                hps[i]       <= '0;
                escape_pulse <= 1'b1;
              end else begin
                ys[i] <= y_new;
              end
            end
          end
          if (idx == LAST) begin
            if (spawn_cnt == CNT_TOP) begin
              spawn_cnt <= '0;
              state     <= SPAWN;
            end else begin
              spawn_cnt <= spawn_cnt + 16'd1;
              state     <= IDLE;
              ready     <= 1'b1;
            end
          end else begin
            idx <= idx + 3'd1;
          end
        end
        SPAWN: begin
          if (frame_tick) pending <= 1'b1;
          for (int i = 0; i < N_SLOTS; i++) begin
            if (free_ok && free_idx == 3'(i)) begin
              act[i] <= 1'b1;
              xs[i]  <= new_x;
              ys[i]  <= 10'(Y_START);
              tys[i] <= new_ty;
              hps[i] <= new_hp;
            end
          end
          state <= IDLE;
          ready <= 1'b1;
        end
        default: begin
          state <= IDLE;
          ready <= 1'b0;
        end
      endcase
    end
  end

  assign enemy_active = act;

  for (genvar g = 0; g < N_SLOTS; g++) begin : g_pack
    assign enemy_x[10*g +: 10]     = xs[g];
    assign enemy_y[10*g +: 10]     = ys[g];
    assign enemy_type[2*g +: 2]    = tys[g];
    assign enemy_health[4*g +: 4]  = hps[g];
  end
endmodule

// File: tb/tb_enemy_manager.sv
// tb_enemy_manager: directed + randomized checks of enemy_manager
// against a frame-level model of the slot rules.
`timescale 1ns/1ps
module tb_enemy_manager;
  localparam int N = 5;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           frame_tick = 1'b0;
  logic [N-1:0]   enemy_active;
  logic [10*N-1:0] enemy_x;
  logic [10*N-1:0] enemy_y;
  logic [2*N-1:0] enemy_type;
  logic [4*N-1:0] enemy_health;
  logic           kill_pulse;
  logic [1:0]     kill_type;
  logic           escape_pulse;

  enemy_manager_if hif ();

  enemy_manager dut (
    .clk          (clk),
    .reset        (reset),
    .frame_tick   (frame_tick),
    .hit          (hif),
    .enemy_active (enemy_active),
    .enemy_x      (enemy_x),
    .enemy_y      (enemy_y),
    .enemy_type   (enemy_type),
    .enemy_health (enemy_health),
    .kill_pulse   (kill_pulse),
    .kill_type    (kill_type),
    .escape_pulse (escape_pulse)
  );

  always #5 clk = ~clk;

  // Number of clock edges since reset was released
  int ecount = 0;
  always @(posedge clk) begin
    if (reset) ecount <= 0;
    else ecount <= ecount + 1;
  end

  int checks = 0;
  int fails  = 0;

  bit m_act [N];
  int m_x [N];
  int m_y [N];
  int m_ty [N];
  int m_hp [N];
  int m_cnt   = 0;
  int m_kills = 0;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] want);
    checks++;
    assert (obs === want) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, want);
    end
  endtask

  function automatic logic [15:0] lfsr_at(input int n);
    logic [15:0] l;
    l = 16'hACE1;
    for (int k = 0; k < n; k++)
      l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    return l;
  endfunction

  task automatic m_clear(input int i);
    m_act[i] = 1'b0;
    m_x[i] = 0;
    m_y[i] = 0;
    m_ty[i] = 0;
    m_hp[i] = 0;
  endtask

  task automatic m_reset();
    for (int i = 0; i < N; i++) m_clear(i);
    m_cnt = 0;
    m_kills = 0;
  endtask

  task automatic m_spawn(input logic [15:0] l);
    int f;
    f = -1;
    for (int i = 0; i < N; i++)
      if (!m_act[i] && f < 0) f = i;
    if (f >= 0) begin
      m_act[f] = 1'b1;
      m_x[f] = 64 + int'(l & 16'h01ff);
      m_y[f] = 8;
      m_ty[f] = int'((l >> 9) & 16'h3);
      if (m_ty[f] == 3) m_ty[f] = 2;
      m_hp[f] = (m_ty[f] == 0) ? 1 : (m_ty[f] == 1) ? 3 : 4;
    end
  endtask

  task automatic m_frame(input int e, output int esc, output bit sp);
    int st;
    int ny;
    st = 1;
`ifdef ENEMY_SPEEDUP_EN
    st = st + m_kills / 16;
`endif
    esc = 0;
    sp = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (m_act[i]) begin
        ny = (m_y[i] + st) % 1024;
        if (ny >= 472) begin
          m_clear(i);
          esc++;
        end else begin
          m_y[i] = ny;
        end
      end
    end
    m_cnt++;
    if (m_cnt == 60) begin
      m_cnt = 0;
      sp = 1'b1;
      m_spawn(lfsr_at(e));
    end
  endtask

  task automatic m_hit(input int s, output bit killed, output int kt);
    killed = 1'b0;
    kt = 0;
    if (s < N && m_act[s]) begin
      if (m_hp[s] > 1) begin
        m_hp[s]--;
      end else begin
        killed = 1'b1;
        kt = m_ty[s];
        m_clear(s);
        if (m_kills < 63) m_kills++;
      end
    end
  endtask

  task automatic check_slots(input string tag);
    logic [63:0] a, x, y, t, h;
    a = '0; x = '0; y = '0; t = '0; h = '0;
    for (int i = 0; i < N; i++) begin
      a[i] = m_act[i];
      x[10*i +: 10] = 10'(m_x[i]);
      y[10*i +: 10] = 10'(m_y[i]);
      t[2*i +: 2] = 2'(m_ty[i]);
      h[4*i +: 4] = 4'(m_hp[i]);
    end
    chk({tag, "_active"}, 64'(enemy_active), a);
    chk({tag, "_x"}, 64'(enemy_x), x);
    chk({tag, "_y"}, 64'(enemy_y), y);
    chk({tag, "_type"}, 64'(enemy_type), t);
    chk({tag, "_health"}, 64'(enemy_health), h);
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while (hif.hit_ready !== 1'b1 && k < 50) begin
      @(negedge clk);
      k++;
    end
    if (k >= 50) chk("idle_timeout", 64'(hif.hit_ready), 64'd1);
  endtask

  task automatic do_hit(input int s);
    bit killed;
    int kt;
    wait_idle();
    hif.hit_valid = 1'b1;
    hif.hit_slot = 3'(s);
    @(negedge clk);
    hif.hit_valid = 1'b0;
    m_hit(s, killed, kt);
    chk("hit_kill_pulse", 64'(kill_pulse), 64'(killed));
    if (killed) chk("hit_kill_type", 64'(kill_type), 64'(kt));
    chk("hit_ready_held", 64'(hif.hit_ready), 64'd1);
    @(negedge clk);
    chk("kill_one_cycle", 64'(kill_pulse), 64'd0);
    check_slots("hit");
  endtask

  task automatic do_frame(input bit with_hit, input int s);
    int e, lows, esc, kills, mesc, kt;
    bit killed, sp;
    wait_idle();
    e = ecount + N + 1;
    frame_tick = 1'b1;
    if (with_hit) begin
      hif.hit_valid = 1'b1;
      hif.hit_slot = 3'(s);
    end
    @(negedge clk);
    frame_tick = 1'b0;
    hif.hit_valid = 1'b0;
    killed = 1'b0;
    kt = 0;
    if (with_hit) begin
      m_hit(s, killed, kt);
      if (killed) chk("tick_kill_type", 64'(kill_type), 64'(kt));
    end
    lows = 0; esc = 0; kills = 0;
    for (int k = 0; k < 40; k++) begin
      if (escape_pulse) esc++;
      if (kill_pulse) kills++;
      if (hif.hit_ready) break;
      lows++;
      @(negedge clk);
    end
    m_frame(e, mesc, sp);
    chk("escape_count", 64'(esc), 64'(mesc));
    chk("kill_count", 64'(kills), 64'(killed));
    chk("ready_low", 64'(lows), 64'(N + int'(sp)));
    check_slots("frame");
  endtask

  task automatic do_pending();
    int mesc;
    bit sp;
    wait_idle();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    wait_idle();
    @(negedge clk);
    chk("pending_move", 64'(hif.hit_ready), 64'd0);
    wait_idle();
    @(negedge clk);
    chk("second_tick_dropped", 64'(hif.hit_ready), 64'd1);
    m_frame(0, mesc, sp);
    m_frame(0, mesc, sp);
    check_slots("pending");
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_active"}, 64'(enemy_active), 64'd0);
    chk({tag, "_x"}, 64'(enemy_x), 64'd0);
    chk({tag, "_y"}, 64'(enemy_y), 64'd0);
    chk({tag, "_type"}, 64'(enemy_type), 64'd0);
    chk({tag, "_health"}, 64'(enemy_health), 64'd0);
    chk({tag, "_ready"}, 64'(hif.hit_ready), 64'd0);
    chk({tag, "_kill"}, 64'(kill_pulse), 64'd0);
    chk({tag, "_ktype"}, 64'(kill_type), 64'd0);
    chk({tag, "_escape"}, 64'(escape_pulse), 64'd0);
  endtask

  initial begin
    int r;
    hif.hit_valid = 1'b0;
    hif.hit_slot = 3'd0;
    m_reset();
    repeat (3) @(negedge clk);
    chk_zero("reset");
    reset = 1'b0;

    do_pending();
    do_hit(3);
    do_hit(6);

    for (int f = 0; f < 58; f++) do_frame(1'b0, 0);
    chk("spawn_slot0", 64'(enemy_active), 64'b00001);
    chk("spawn_y", 64'(enemy_y[9:0]), 64'd8);

    for (int k = 0; k < 4; k++)
      if (m_act[0]) do_hit(0);
    chk("slot0_cleared", 64'(enemy_active[0]), 64'd0);

    for (int f = 0; f < 560; f++) begin
      r = int'($urandom_range(0, 9));
      if (r == 0) do_hit(int'($urandom_range(5, 7)));
      do_frame(r == 1, int'($urandom_range(5, 7)));
    end

    for (int f = 0; f < 100; f++) begin
      r = int'($urandom_range(0, 5));
      if (r < 2) do_hit(int'($urandom_range(0, 7)));
      do_frame(r == 2, int'($urandom_range(0, 7)));
    end

    wait_idle();
    frame_tick = 1'b1;
    @(negedge clk);
    frame_tick = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("mid_move_reset");
    reset = 1'b0;
    m_reset();
    do_frame(1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end
endmodule
